// File: rtl/hyper_rr_arbiter_if.sv
// Request/grant bundle between uDMA requesters, the round-robin arbiter and
// the HyperBus transaction engine.
interface hyper_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 8,
    parameter int PTR_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ*LEN_W-1:0] len_i;
    logic [NUM_REQ-1:0]       gnt_o;
    logic                     out_req_o;
    logic [PTR_W-1:0]         out_id_o;
    logic                     out_last_o;
    logic                     out_gnt_i;
    logic                     busy_o;
    logic [PTR_W-1:0]         rr_ptr_o;

    // master: requesters plus transaction engine; slave: the arbiter
    modport master (
        output req_i, len_i, out_gnt_i,
        input  gnt_o, out_req_o, out_id_o, out_last_o, busy_o, rr_ptr_o
    );
    modport slave (
        input  req_i, len_i, out_gnt_i,
        output gnt_o, out_req_o, out_id_o, out_last_o, busy_o, rr_ptr_o
    );
endinterface

// File: rtl/hyper_rr_arbiter.sv
// Round-robin arbiter for HyperBus uDMA requesters; locks the winner for the
// whole burst and rotates priority only once a burst has fully completed.
module hyper_rr_gnt_cell #(
    parameter int PTR_W = 2,
    parameter int IDX   = 0
) (
    input  logic             hs,
    input  logic [PTR_W-1:0] id,
    output logic             gnt
);
    assign gnt = hs && (id == PTR_W'(IDX));
endmodule

module hyper_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 8,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input logic               clk,
    input logic               rst_n,
    hyper_rr_arbiter_if.slave bus
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                          state;
    logic [PTR_W-1:0]                rr_ptr;
    logic [PTR_W-1:0]                owner;
    logic [LEN_W-1:0]                beats_left;
    logic [PTR_W-1:0]                sel;
    logic [LEN_W-1:0]                sel_len;
    logic [NUM_REQ-1:0][LEN_W-1:0]   len_arr;
    logic [NUM_REQ-1:0]              gnt;
    logic                            out_req;
    logic [PTR_W-1:0]                out_id;
    logic                            out_last;
    logic                            hs;

    // Explicit wrap so non-power-of-two counts never reach an unused index.
    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] k);
        return (int'(k) == NUM_REQ-1) ? '0 : k + 1'b1;
    endfunction

    assign len_arr = bus.len_i;

    always_comb begin
        logic             found;
        int               idx;
        logic [PTR_W-1:0] cand;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = PTR_W'(idx);
            if (!found && bus.req_i[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign sel_len = len_arr[sel];

    always_comb begin
        out_req  = 1'b0;
        out_id   = '0;
        out_last = 1'b0;
        if (state == LOCKED) begin
            out_req  = bus.req_i[owner];
            out_id   = owner;
            out_last = (beats_left == LEN_W'(1));
        end else begin
            out_req  = |bus.req_i;
            out_id   = sel;
            out_last = (sel_len == '0);
        end
    end

    assign hs = out_req & bus.out_gnt_i;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
        hyper_rr_gnt_cell #(.PTR_W(PTR_W), .IDX(k)) u_cell (
            .hs  (hs),
            .id  (out_id),
            .gnt (gnt[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            beats_left <= '0;
        end else begin
            case (state)
                IDLE: if (hs) begin
                    if (sel_len == '0) begin
                        rr_ptr <= next_idx(sel);
                    end else begin
                        owner      <= sel;
                        beats_left <= sel_len;
                        state      <= LOCKED;
                    end
                end
                LOCKED: if (hs) begin
                    beats_left <= beats_left - 1'b1;
                    if (beats_left == LEN_W'(1)) begin
                        state  <= IDLE;
                        rr_ptr <= next_idx(owner);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt_o      = gnt;
    assign bus.out_req_o  = out_req;
    assign bus.out_id_o   = out_id;
    assign bus.out_last_o = out_last;
    assign bus.busy_o     = (state == LOCKED);
    assign bus.rr_ptr_o   = rr_ptr;
endmodule
